hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RV32IM core (IF/ID/EX/MEM/WB).
- Consumes the decoded fields of the instruction in ID (opcode, func3, func7, register indices).
- Keeps shadow copies of the EX/MEM/WB stage register usage.
- Drives stall, bubble and flush controls for the pipeline registers, plus the EX-stage forwarding selects.
- Sequences multi-cycle divide operations with an internal latency counter and freezes the pipe on memory wait.

Parameters:
MDU_LAT, 8, total EX-stage cycles for DIV/DIVU/REM/REMU (minimum 1; MUL is single-cycle).

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_opcode  input  7  ID opcode
id_func3  input  3  ID func3
id_func7  input  2  ID {inst[30], inst[25]}
id_rs1_index  input  5  ID rs1
id_rs2_index  input  5  ID rs2
id_rd_index  input  5  ID rd
ex_branch_taken  input  1  EX branch/jump redirects PC this cycle
mem_wait  input  1  IM or DM not ready; whole pipe must freeze
stall_if  output  1  hold PC
stall_id  output  1  hold IF/ID register
stall_ex  output  1  hold ID/EX register
flush_id  output  1  load NOP into IF/ID
bubble_ex  output  1  load NOP into ID/EX
bubble_mem  output  1  load NOP into EX/MEM
fwd_rs1_sel  output  2  EX rs1 source: 00 regfile, 01 MEM, 10 WB
fwd_rs2_sel  output  2  EX rs2 source, same encoding
load_use  output  1  load-use stall active (debug/perf counter)
mdu_busy  output  1  divide in progress

Behaviour:
Decode classes (ID):
- Reads rs1: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, JALR 1100111; CSR 1110011 only when func3[2]=0.
- Reads rs2: R, store, branch.
- Writes rd: R, I-ALU, load, JAL 1101111, JALR, LUI 0110111, AUIPC 0010111, CSR.
- rd/rs index 0 never counts as a dependence.
- Divide: opcode 0110011, id_func7[0]=1, id_func3[2]=1.

Shadow state:
- EX stage: valid, rs1, rs2, rd, regwrite, is_load.
- MEM stage: valid, rd, regwrite, is_load.
- WB stage: valid, rd, regwrite.
- div counter cnt, width clog2(MDU_LAT)+1.

Combinational outputs, in priority order:
1. mem_wait=1: stall_if=stall_id=stall_ex=1; flush_id=bubble_ex=bubble_mem=0; load_use=0.
2. cnt!=0 (divide in EX): stall_if=stall_id=stall_ex=1; bubble_mem=1. No branch can be in EX, so ex_branch_taken is ignored.
3. ex_branch_taken and EX valid: flush_id=1, bubble_ex=1, no stalls. Load-use is suppressed because the ID instruction is dead.
4. Load-use: EX valid & is_load & rd!=0 & id_valid, and rd equals a used ID rs. Then stall_if=stall_id=1, bubble_ex=1, load_use=1 for one cycle.
5. Otherwise all 0.

mdu_busy = (cnt!=0).

Forwarding (EX shadow, independent of stalls):
- Select 01 if MEM valid & regwrite & !is_load & rd!=0 & rd==ex_rs.
- Else select 10 if WB valid & regwrite & rd!=0 & rd==ex_rs.
- Else select 00. MEM wins over WB.

Sequential update on rising clk:
- mem_wait=1: all shadow registers hold.
- stall_ex=1: EX holds; MEM<=invalid; WB<=MEM.
- Otherwise:
  - EX<=ID fields with valid=id_valid & !bubble_ex.
  - MEM<=EX; WB<=MEM.
- Divide entering EX (ID is divide, not bubbled, advancing): cnt<=MDU_LAT-1.
- Else if cnt!=0: cnt<=cnt-1. The counter decrements even during mem_wait, because the MDU runs independently.
- MDU_LAT=1: cnt stays 0 and there is no stall.

Reset: all shadow valid bits=0, cnt=0. Every output is 0 during and right after reset. Reset asserted mid-divide clears cnt immediately (asynchronously).

Test Plan:
- Load-use: LW x5 in EX, ADD x6,x5,x1 in ID -> one cycle with stall_if=stall_id=bubble_ex=load_use=1. Next cycle none; on the following cycle ADD in EX has fwd_rs1_sel=10.
- Back-to-back ALU: ADD x3 then SUB x4,x3,x3 -> with SUB in EX, fwd_rs1_sel=fwd_rs2_sel=01 and no stall. Repeat with rd=x0 -> selects 00.
- Divide, MDU_LAT=8: DIV enters EX -> stall_ex=mdu_busy=bubble_mem=1 for exactly 7 cycles, then the pipe advances. With MDU_LAT=1 there is no stall.
- Branch vs load-use: taken BEQ in EX while ID has a load-use dependence -> flush_id=bubble_ex=1, load_use=0, stall_if=0.
- mem_wait held 3 cycles during load-use -> all stalls=1, bubbles=0, shadows frozen. The load-use stall resumes after mem_wait drops.
- Reset asserted with cnt=5 -> mdu_busy=0 asynchronously, all outputs 0, fwd selects 00.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32IM pipeline: stall/bubble/flush
// generation, EX operand forwarding selects and multi-cycle divide sequencing.
module hazard_ctrl #(
  parameter int MDU_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [2:0] id_func3,
  input  logic [1:0] id_func7,
  input  logic [4:0] id_rs1_index,
  input  logic [4:0] id_rs2_index,
  input  logic [4:0] id_rd_index,
  input  logic       ex_branch_taken,
  input  logic       mem_wait,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       flush_id,
  output logic       bubble_ex,
  output logic       bubble_mem,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel,
  output logic       load_use,
  output logic       mdu_busy
);

  localparam int CW = $clog2(MDU_LAT) + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic          id_reads_rs1, id_reads_rs2, id_writes_rd, id_is_load, id_is_div;
  logic          ex_valid, ex_regwrite, ex_is_load;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic          mem_valid, mem_regwrite, mem_is_load;
  logic [4:0]    mem_rd;
  logic          wb_valid, wb_regwrite;
  logic [4:0]    wb_rd;
  logic [CW-1:0] cnt;
  logic          lu_hazard, div_enter, mem_fwd_ok, wb_fwd_ok;
  logic          unused_bits;

  assign unused_bits = ^{id_func3[1:0], id_func7[1]};

  always_comb begin
    id_reads_rs1 = 1'b0;
    id_reads_rs2 = 1'b0;
    id_writes_rd = 1'b0;
    id_is_load   = 1'b0;
    case (id_opcode)
      OP_R:      begin id_reads_rs1 = 1'b1; id_reads_rs2 = 1'b1; id_writes_rd = 1'b1; end
      OP_I_ALU:  begin id_reads_rs1 = 1'b1; id_writes_rd = 1'b1; end
      OP_LOAD:   begin id_reads_rs1 = 1'b1; id_writes_rd = 1'b1; id_is_load = 1'b1; end
      OP_STORE:  begin id_reads_rs1 = 1'b1; id_reads_rs2 = 1'b1; end
      OP_BRANCH: begin id_reads_rs1 = 1'b1; id_reads_rs2 = 1'b1; end
      OP_JALR:   begin id_reads_rs1 = 1'b1; id_writes_rd = 1'b1; end
      OP_JAL, OP_LUI, OP_AUIPC: id_writes_rd = 1'b1;
      // Immediate CSR forms (func3[2]=1) take a zimm, not rs1.
      OP_SYSTEM: begin id_reads_rs1 = ~id_func3[2]; id_writes_rd = 1'b1; end
      default: ;
    endcase
  end

  assign id_is_div = (id_opcode == OP_R) && id_func7[0] && id_func3[2];

  assign lu_hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                     ((id_reads_rs1 && (id_rs1_index == ex_rd)) ||
                      (id_reads_rs2 && (id_rs2_index == ex_rd)));

  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    flush_id   = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    load_use   = 1'b0;
    if (rst) begin
    end else if (mem_wait) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (cnt != '0) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      bubble_mem = 1'b1;
    end else if (ex_branch_taken && ex_valid) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (lu_hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      load_use  = 1'b1;
    end
  end

  assign mdu_busy = (cnt != '0);

  // Loads still in MEM have no data yet, so only WB may forward them.
  assign mem_fwd_ok  = mem_valid && mem_regwrite && !mem_is_load && (mem_rd != 5'd0);
  assign wb_fwd_ok   = wb_valid && wb_regwrite && (wb_rd != 5'd0);
  assign fwd_rs1_sel = (mem_fwd_ok && (mem_rd == ex_rs1)) ? 2'b01 :
                       (wb_fwd_ok  && (wb_rd  == ex_rs1)) ? 2'b10 : 2'b00;
  assign fwd_rs2_sel = (mem_fwd_ok && (mem_rd == ex_rs2)) ? 2'b01 :
                       (wb_fwd_ok  && (wb_rd  == ex_rs2)) ? 2'b10 : 2'b00;

  assign div_enter = !mem_wait && !stall_ex && id_valid && !bubble_ex && id_is_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rd        <= 5'd0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_is_load  <= 1'b0;
      mem_rd       <= 5'd0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= 5'd0;
      cnt          <= '0;
    end else begin
      // The divider keeps counting through memory waits.
      if (div_enter) begin
        cnt <= CW'(MDU_LAT - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (!mem_wait) begin
        wb_valid    <= mem_valid;
        wb_regwrite <= mem_regwrite;
        wb_rd       <= mem_rd;
        if (stall_ex) begin
          mem_valid <= 1'b0;
        end else begin
          mem_valid    <= ex_valid;
          mem_regwrite <= ex_regwrite;
          mem_is_load  <= ex_is_load;
          mem_rd       <= ex_rd;
          ex_valid     <= id_valid && !bubble_ex;
          ex_regwrite  <= id_writes_rd;
          ex_is_load   <= id_is_load;
          ex_rs1       <= id_rs1_index;
          ex_rs2       <= id_rs2_index;
          ex_rd        <= id_rd_index;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed hazard scenarios followed by random instruction
// streams, all checked against an instruction-level pipeline model.
module tb_hazard_ctrl;

  localparam int LAT = 8;

  localparam int K_ADD = 0, K_SUB = 1, K_MUL = 2, K_DIV = 3, K_REMU = 4, K_ADDI = 5;
  localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_JAL = 9, K_JALR = 10, K_LUI = 11;
  localparam int K_AUIPC = 12, K_CSRRW = 13, K_CSRRWI = 14, K_FENCE = 15, K_XOR = 16;

  typedef struct {
    bit       valid;
    int       kind;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, ex_branch_taken, mem_wait;
  logic [6:0] id_opcode;
  logic [2:0] id_func3;
  logic [1:0] id_func7;
  logic [4:0] id_rs1_index, id_rs2_index, id_rd_index;
  logic       stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem, load_use, mdu_busy;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic       l1_stall_ex, l1_mdu_busy;
  logic       l1_unused_sif, l1_unused_sid, l1_unused_fid, l1_unused_bex, l1_unused_bmem, l1_unused_lu;
  logic [1:0] l1_unused_f1, l1_unused_f2;

  int    total = 0;
  int    bad = 0;
  slot_t m_ex, m_mem, m_wb;
  int    div_left;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_func3(id_func3),
    .id_func7(id_func7), .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_rd_index(id_rd_index), .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel), .load_use(load_use), .mdu_busy(mdu_busy)
  );

  hazard_ctrl #(.MDU_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_func3(id_func3),
    .id_func7(id_func7), .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_rd_index(id_rd_index), .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall_if(l1_unused_sif), .stall_id(l1_unused_sid), .stall_ex(l1_stall_ex),
    .flush_id(l1_unused_fid), .bubble_ex(l1_unused_bex), .bubble_mem(l1_unused_bmem),
    .fwd_rs1_sel(l1_unused_f1), .fwd_rs2_sel(l1_unused_f2), .load_use(l1_unused_lu),
    .mdu_busy(l1_mdu_busy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction properties as {reads rs1, reads rs2, writes rd, is load, is divide}.
  function automatic logic [4:0] props(input int kind);
    case (kind)
      K_ADD, K_SUB, K_MUL, K_XOR: return 5'b11100;
      K_DIV, K_REMU:              return 5'b11101;
      K_ADDI, K_JALR, K_CSRRW:    return 5'b10100;
      K_LW:                       return 5'b10110;
      K_SW, K_BEQ:                return 5'b11000;
      K_JAL, K_LUI, K_AUIPC, K_CSRRWI: return 5'b00100;
      default:                    return 5'b00000;
    endcase
  endfunction

  task automatic encodeKind(input int kind, output logic [6:0] op, output logic [2:0] f3,
                            output logic [1:0] f7);
    f3 = 3'b000;
    f7 = 2'b00;
    case (kind)
      K_ADD:    op = 7'b0110011;
      K_SUB:    begin op = 7'b0110011; f7 = 2'b10; end
      K_MUL:    begin op = 7'b0110011; f7 = 2'b01; end
      K_DIV:    begin op = 7'b0110011; f3 = 3'b100; f7 = 2'b01; end
      K_REMU:   begin op = 7'b0110011; f3 = 3'b111; f7 = 2'b01; end
      K_XOR:    begin op = 7'b0110011; f3 = 3'b100; end
      K_ADDI:   begin op = 7'b0010011; f3 = 3'b101; f7 = 2'b01; end
      K_LW:     begin op = 7'b0000011; f3 = 3'b010; end
      K_SW:     begin op = 7'b0100011; f3 = 3'b010; end
      K_BEQ:    op = 7'b1100011;
      K_JAL:    op = 7'b1101111;
      K_JALR:   op = 7'b1100111;
      K_LUI:    op = 7'b0110111;
      K_AUIPC:  op = 7'b0010111;
      K_CSRRW:  begin op = 7'b1110011; f3 = 3'b001; end
      K_CSRRWI: begin op = 7'b1110011; f3 = 3'b101; end
      default:  op = 7'b0001111;
    endcase
  endtask

  task automatic modelReset();
    m_ex = '{default: 0};
    m_mem = '{default: 0};
    m_wb = '{default: 0};
    div_left = 0;
  endtask

  function automatic logic [1:0] modelFwd(input bit [4:0] r);
    logic [4:0] pm, pw;
    pm = props(m_mem.kind);
    pw = props(m_wb.kind);
    if (m_mem.valid && pm[2] && !pm[1] && m_mem.rd != 0 && m_mem.rd == r) return 2'b01;
    if (m_wb.valid && pw[2] && m_wb.rd != 0 && m_wb.rd == r) return 2'b10;
    return 2'b00;
  endfunction

  // One clock cycle: drive ID/control inputs, compare every output, then advance the model.
  task automatic applyStimulus(input int kind, input bit [4:0] rs1, input bit [4:0] rs2,
                               input bit [4:0] rd, input bit idv, input bit br, input bit mw);
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] f7;
    logic [4:0] ip, ep;
    bit e_sif, e_sid, e_sex, e_fid, e_bex, e_bmem, e_lu, busy, entering;
    @(negedge clk);
    encodeKind(kind, op, f3, f7);
    id_valid = idv; id_opcode = op; id_func3 = f3; id_func7 = f7;
    id_rs1_index = rs1; id_rs2_index = rs2; id_rd_index = rd;
    ex_branch_taken = br; mem_wait = mw;
    #1;
    ip = props(kind);
    ep = props(m_ex.kind);
    busy = (div_left > 0);
    {e_sif, e_sid, e_sex, e_fid, e_bex, e_bmem, e_lu} = 7'b0;
    if (mw) {e_sif, e_sid, e_sex} = 3'b111;
    else if (busy) {e_sif, e_sid, e_sex, e_bmem} = 4'b1111;
    else if (br && m_ex.valid) {e_fid, e_bex} = 2'b11;
    else if (m_ex.valid && ep[1] && m_ex.rd != 0 && idv &&
             ((ip[4] && rs1 == m_ex.rd) || (ip[3] && rs2 == m_ex.rd)))
      {e_sif, e_sid, e_bex, e_lu} = 4'b1111;
    checkOutput("stalls", {5'b0, stall_if, stall_id, stall_ex}, {5'b0, e_sif, e_sid, e_sex});
    checkOutput("bubbles", {5'b0, flush_id, bubble_ex, bubble_mem}, {5'b0, e_fid, e_bex, e_bmem});
    checkOutput("load_use", {7'b0, load_use}, {7'b0, e_lu});
    checkOutput("mdu_busy", {7'b0, mdu_busy}, {7'b0, busy});
    checkOutput("fwd_rs1", {6'b0, fwd_rs1_sel}, {6'b0, modelFwd(m_ex.rs1)});
    checkOutput("fwd_rs2", {6'b0, fwd_rs2_sel}, {6'b0, modelFwd(m_ex.rs2)});
    checkOutput("lat1_busy", {7'b0, l1_mdu_busy}, 8'h00);
    checkOutput("lat1_stall_ex", {7'b0, l1_stall_ex}, {7'b0, mw});
    @(posedge clk);
    entering = !mw && !busy && idv && !e_bex && ip[0];
    if (entering) div_left = LAT - 1;
    else if (div_left > 0) div_left--;
    if (!mw) begin
      m_wb = m_mem;
      if (busy) m_mem.valid = 0;
      else begin
        m_mem = m_ex;
        m_ex = '{valid: idv && !e_bex, kind: kind, rs1: rs1, rs2: rs2, rd: rd};
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem,
                                load_use, mdu_busy}, 8'h00);
    checkOutput({tag, "_fwd"}, {4'b0, fwd_rs1_sel, fwd_rs2_sel}, 8'h00);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) applyStimulus(K_FENCE, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    {id_valid, ex_branch_taken, mem_wait} = 3'b000;
    id_opcode = 7'd0; id_func3 = 3'd0; id_func7 = 2'd0;
    id_rs1_index = 5'd0; id_rs2_index = 5'd0; id_rd_index = 5'd0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load-use: LW x5 then ADD x6,x5,x1 held in ID until it issues.
    nops(3);
    applyStimulus(K_LW, 1, 0, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(K_ADD, 5, 1, 6, 1, 0, 0);
    // Back-to-back ALU, then the same with rd=x0.
    nops(3);
    applyStimulus(K_ADD, 1, 2, 3, 1, 0, 0);
    applyStimulus(K_SUB, 3, 3, 4, 1, 0, 0);
    nops(2);
    applyStimulus(K_ADD, 1, 2, 0, 1, 0, 0);
    applyStimulus(K_SUB, 0, 0, 4, 1, 0, 0);
    nops(2);
    // Divide occupies EX for the full latency; XOR with func3[2]=1 is not a divide.
    applyStimulus(K_DIV, 1, 2, 7, 1, 0, 0);
    for (int i = 0; i < LAT + 1; i++) applyStimulus(K_ADD, 7, 1, 8, 1, 0, 0);
    applyStimulus(K_XOR, 1, 2, 9, 1, 0, 0);
    nops(2);
    // Taken branch outranks a pending load-use.
    applyStimulus(K_LW, 1, 0, 5, 1, 0, 0);
    applyStimulus(K_ADD, 5, 1, 6, 1, 1, 0);
    nops(2);
    // Memory wait during load-use, then the stall resumes.
    applyStimulus(K_LW, 1, 0, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(K_ADD, 5, 1, 6, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(K_ADD, 5, 1, 6, 1, 0, 0);

    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 16), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), $urandom_range(0, 7) != 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of a divide clears the busy state immediately.
    nops(6);
    applyStimulus(K_DIV, 1, 2, 3, 1, 0, 0);
    applyStimulus(K_ADD, 3, 1, 4, 1, 0, 0);
    applyStimulus(K_ADD, 3, 1, 4, 1, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    nops(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
